// File: rtl/mem_align_pkg.sv
// mem_align_pkg: shared size/error encodings, FSM state type and size helper
// Contents:
//   SZ_B/SZ_H/SZ_W/SZ_D      request size encodings (byte, half, word, dword)
//   ERR_OK/ERR_MISALIGN/...  rsp_err codes
//   state_t                  IDLE, WAIT, RESP
//   bytes_of(size)           access width in bytes (1, 2, 4, 8)
package mem_align_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// mem_align_unit_if: request, memory-port and response signals of the align unit
// Modports:
//   slave   the align unit (accepts requests, drives memory and responses)
//   master  the requester/memory side (drives requests, ack and read data)
interface mem_align_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [1:0]        rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_err, rsp_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/lane_extract.sv
// lane_extract: pick a byte/half/word/dword field at a lane offset and extend it
// Ports:
//   data    in  DATA_W        source word (little-endian lanes)
//   offset  in  log2(DATA_W/8) starting byte lane of the field
//   size    in  2             field size encoding
//   uns     in  1             zero-extend instead of sign-extend
//   res     out DATA_W        right-justified, extended field
module lane_extract
    import mem_align_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]           data,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [1:0]                  size,
    input  logic                        uns,
    output logic [DATA_W-1:0]           res
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] sh, up;
    logic signed [DATA_W-1:0] sx;
    logic [6:0] sft;

    // Park the field at the top of the word, then shift back down: a logical
    // shift zero-extends, an arithmetic one sign-extends from the field MSB.
    always_comb begin
        sft = 7'(DATA_W) - (bytes_of(size) > 4'(NB) ? 7'(DATA_W) : 7'(8 * bytes_of(size)));
        sh  = data >> {offset, 3'b000};
        up  = sh << sft;
        sx  = $signed(up) >>> sft;
        res = uns ? up >> sft : sx;
    end

endmodule

// File: rtl/mem_align_unit.sv
// mem_align_unit: one aligned load/store beat per request with lane extract/replicate
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of mem_align_unit_if:
//            req_*  request handshake (valid/ready, we, size, unsigned, addr, wdata)
//            mem_*  single-beat memory port (req, we, addr, be, wdata, ack, rdata)
//            rsp_*  completion pulse, error code, held load result
module mem_align_unit
    import mem_align_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst_n,
    mem_align_unit_if.slave bus
);

    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    state_t            state, state_n;
    logic [OW-1:0]     off_q, off_n;
    logic [1:0]        size_q, size_n;
    logic              uns_q, uns_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              req_n, we_n, vld_n;
    logic [ADDR_W-1:0] addr_n;
    logic [NB-1:0]     be_n;
    logic [DATA_W-1:0] wd_n, rd_n, ld_res, st_field, rep;
    logic [1:0]        err_n;
    logic [3:0]        nbytes;
    logic              bad_size, misal, timed_out;

    lane_extract #(.DATA_W(DATA_W)) u_ld (
        .data(bus.mem_rdata), .offset(off_q), .size(size_q), .uns(uns_q), .res(ld_res)
    );

    // Store path reuses the extractor at offset 0 to isolate the field.
    lane_extract #(.DATA_W(DATA_W)) u_st (
        .data(bus.req_wdata), .offset('0), .size(bus.req_size), .uns(1'b1), .res(st_field)
    );

    assign nbytes        = bytes_of(bus.req_size);
    assign bad_size      = bus.req_size == SZ_D && DATA_W == 32;
    assign misal         = |(bus.req_addr[2:0] & 3'(nbytes - 4'd1));
    assign timed_out     = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    assign bus.req_ready = state == IDLE;

    // Lane k carries field byte (k mod size), so every aligned slot holds the field.
    always_comb
        for (int k = 0; k < NB; k++)
            rep[8*k +: 8] = st_field[8*(k & (int'(nbytes) - 1)) +: 8];

    always_comb begin
        state_n = state;
        off_n   = off_q;
        size_n  = size_q;
        uns_n   = uns_q;
        cnt_n   = cnt;
        req_n   = bus.mem_req;
        we_n    = bus.mem_we;
        addr_n  = bus.mem_addr;
        be_n    = bus.mem_be;
        wd_n    = bus.mem_wdata;
        vld_n   = 1'b0;
        err_n   = bus.rsp_err;
        rd_n    = bus.rsp_rdata;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (bad_size || misal) begin
                    state_n = RESP;
                    vld_n   = 1'b1;
                    err_n   = bad_size ? ERR_SIZE : ERR_MISALIGN;
                end else begin
                    state_n = WAIT;
                    off_n   = bus.req_addr[OW-1:0];
                    size_n  = bus.req_size;
                    uns_n   = bus.req_unsigned;
                    cnt_n   = '0;
                    req_n   = 1'b1;
                    we_n    = bus.req_we;
                    addr_n  = bus.req_addr & ~ADDR_W'(NB - 1);
                    be_n    = NB'((9'd1 << nbytes) - 9'd1) << bus.req_addr[OW-1:0];
                    wd_n    = rep;
                end
            end
            WAIT: if (bus.mem_ack) begin
                state_n = RESP;
                req_n   = 1'b0;
                vld_n   = 1'b1;
                err_n   = ERR_OK;
                rd_n    = bus.mem_we ? bus.rsp_rdata : ld_res;
            end else if (timed_out) begin
                state_n = RESP;
                req_n   = 1'b0;
                vld_n   = 1'b1;
                err_n   = ERR_TIMEOUT;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            off_q         <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            cnt           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            state         <= state_n;
            off_q         <= off_n;
            size_q        <= size_n;
            uns_q         <= uns_n;
            cnt           <= cnt_n;
            bus.mem_req   <= req_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= addr_n;
            bus.mem_be    <= be_n;
            bus.mem_wdata <= wd_n;
            bus.rsp_valid <= vld_n;
            bus.rsp_err   <= err_n;
            bus.rsp_rdata <= rd_n;
        end
    end

endmodule
